regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard_pkg.sv | 26 ++
 rtl/regfile_scoreboard_sb_counter.sv | 61 ++++++
 rtl/regfile_scoreboard.sv | 143 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_pkg
// Purpose  : Shared sizing constants and types for the register file with
//            in-flight-write scoreboard.
// Contents : DATA_W, NUM_REGS, REG_SEL_W, SB_CNT_W, SB_CNT_MAX,
//            data_t (register word), sel_t (register select),
//            cnt_t (scoreboard counter).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = $clog2(NUM_REGS);
  localparam int SB_CNT_W  = 2;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_SEL_W-1:0] sel_t;
  typedef logic [SB_CNT_W-1:0]  cnt_t;

  // Deepest number of writes that may be in flight to one register.
  localparam cnt_t SB_CNT_MAX = cnt_t'(3);

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter
// Purpose  : Saturating up/down counter tracking in-flight writes to a single
//            register. Flags an error pulse on overflow or underflow attempts.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            inc           - one more write issued to this register
//            dec           - one write retired from this register
//            cnt           - current in-flight count
//            busy          - count is non-zero
//            err           - this cycle's update would over/underflow
//                            (combinational pulse; counter holds instead)
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic busy,
  output logic err
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == SB_CNT_MAX) begin
        err = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec && !inc) begin
      if (cnt_q == '0) begin
        err = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    // inc && dec: one issue and one retire cancel out.
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule : sb_counter
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 8 x 16-bit architectural register file with one write-back port,
//            two combinational decode read ports, and a per-register
//            scoreboard of in-flight writes that drives a hazard stall.
// Ports    : clk, rst                     - clock, sync active-high reset
//            read1RegSel/read1Use/read1Data - source operand 1
//            read2RegSel/read2Use/read2Data - source operand 2
//            writeRegSel/writeData/writeEn  - write-back (retires one write)
//            issueEn/issueRegSel            - decode issues a destination
//            hazardStall                    - a used source is still pending
//            sbErr                          - sticky over/underflow flag
// Config   : RF_BYPASS_EN - when defined, the write-back value is forwarded
//            to the read ports in the same cycle, and the last pending write
//            of a register no longer causes a stall while it retires.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        read1RegSel,
  input  logic [2:0]        read2RegSel,
  input  logic              read1Use,
  input  logic              read2Use,
  output logic [DATA_W-1:0] read1Data,
  output logic [DATA_W-1:0] read2Data,
  input  logic [2:0]        writeRegSel,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn,
  input  logic              issueEn,
  input  logic [2:0]        issueRegSel,
  output logic              hazardStall,
  output logic              sbErr
);

  // --------------------------------------------------------------------------
  // Register storage
  // --------------------------------------------------------------------------
  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (writeEn) begin
      regs_d[writeRegSel] = writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  always_comb begin
    read1Data = regs_q[read1RegSel];
    read2Data = regs_q[read2RegSel];
`ifdef RF_BYPASS_EN
    if (writeEn && (writeRegSel == read1RegSel)) begin
      read1Data = writeData;
    end
    if (writeEn && (writeRegSel == read2RegSel)) begin
      read2Data = writeData;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_pend;
  logic [NUM_REGS-1:0] w_cnt_err;
  cnt_t                w_cnt [NUM_REGS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    logic w_inc;
    logic w_dec;
    logic w_retire_last;

    assign w_inc = issueEn && (issueRegSel == sel_t'(r));
    assign w_dec = writeEn && (writeRegSel == sel_t'(r));

    sb_counter u_sb_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (w_inc),
      .dec  (w_dec),
      .cnt  (w_cnt[r]),
      .busy (w_busy[r]),
      .err  (w_cnt_err[r])
    );

`ifdef RF_BYPASS_EN
    // The only outstanding write is retiring right now and its data is
    // forwarded onto the read port, so the operand is already available.
    assign w_retire_last = w_dec && (w_cnt[r] == cnt_t'(1));
`else
    assign w_retire_last = 1'b0;
`endif

    assign w_pend[r] = w_busy[r] && !w_retire_last;
  end

  assign hazardStall = (read1Use && w_pend[read1RegSel]) ||
                       (read2Use && w_pend[read2RegSel]);

  // --------------------------------------------------------------------------
  // Sticky error flag
  // --------------------------------------------------------------------------
  logic sb_err_q;
  logic sb_err_d;

  always_comb begin
    sb_err_d = sb_err_q | (|w_cnt_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sbErr = sb_err_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard. Each table row is one
//            clock cycle: inputs are applied, the combinational outputs are
//            compared against hand-computed values, then the clock advances.
//            Expected values that depend on RF_BYPASS_EN are selected by BP.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic        read1Use;
  logic        read2Use;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic        issueEn;
  logic [2:0]  issueRegSel;
  logic        hazardStall;
  logic        sbErr;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Use    (read1Use),
    .read2Use    (read2Use),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .hazardStall (hazardStall),
    .sbErr       (sbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iss;
    logic [2:0]  iss_sel;
    logic        we;
    logic [2:0]  w_sel;
    logic [15:0] w_data;
    logic [2:0]  s1;
    logic        u1;
    logic [2:0]  s2;
    logic        u2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t vecs [64];
  int   nv;
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(
    input logic        rst_i,
    input logic        iss,
    input logic [2:0]  iss_sel,
    input logic        we,
    input logic [2:0]  w_sel,
    input logic [15:0] w_data,
    input logic [2:0]  s1,
    input logic        u1,
    input logic [2:0]  s2,
    input logic        u2,
    input logic [15:0] e1,
    input logic [15:0] e2,
    input logic        e_stall,
    input logic        e_err
  );
    vec_t v;
    v.rst = rst_i;  v.iss = iss;  v.iss_sel = iss_sel;
    v.we = we;      v.w_sel = w_sel;  v.w_data = w_data;
    v.s1 = s1;      v.u1 = u1;    v.s2 = s2;  v.u2 = u2;
    v.e1 = e1;      v.e2 = e2;    v.e_stall = e_stall;  v.e_err = e_err;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic check16(input string name, input int row,
                         input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic check1(input string name, input int row,
                        input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then clock.
  task automatic apply(input int row, input vec_t v);
    rst         = v.rst;
    issueEn     = v.iss;
    issueRegSel = v.iss_sel;
    writeEn     = v.we;
    writeRegSel = v.w_sel;
    writeData   = v.w_data;
    read1RegSel = v.s1;
    read1Use    = v.u1;
    read2RegSel = v.s2;
    read2Use    = v.u2;
    @(negedge clk);
    check16("read1Data", row, read1Data, v.e1);
    check16("read2Data", row, read2Data, v.e2);
    check1("hazardStall", row, hazardStall, v.e_stall);
    check1("sbErr", row, sbErr, v.e_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nv      = 0;

    rst = 1'b1; issueEn = 1'b0; issueRegSel = '0; writeEn = 1'b0;
    writeRegSel = '0; writeData = '0; read1RegSel = '0; read1Use = 1'b0;
    read2RegSel = '0; read2Use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every register reads zero on both ports, no stall/error.
    for (int s = 0; s < 8; s++) begin
      read1RegSel = 3'(s);
      read2RegSel = 3'(7 - s);
      read1Use    = 1'b1;
      read2Use    = 1'b1;
      @(negedge clk);
      check16("reset_read1", s, read1Data, 16'h0000);
      check16("reset_read2", s, read2Data, 16'h0000);
      check1("reset_stall", s, hazardStall, 1'b0);
      check1("reset_sbErr", s, sbErr, 1'b0);
      @(posedge clk);
      #1;
    end
    read1Use = 1'b0;
    read2Use = 1'b0;

    //     rst iss isel we wsel wdata     s1 u1 s2 u2  e1 e2 stall err
    // Write/read-back of r3 (issued first so the retire is legal).
    add(mk(0, 1, 3, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 1, 3, 16'hBEEF,  3, 0, 0, 0, BP ? 16'hBEEF : 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  3, 1, 0, 0, 16'hBEEF, 16'h0000, 0, 0));
    // Basic hazard on r5.
    add(mk(0, 1, 5, 0, 0, 16'h0000,  0, 0, 5, 1, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 5, 1, 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 0, 0, 1, 5, 16'h1234,  0, 0, 5, 1, 16'h0000, BP ? 16'h1234 : 16'h0000, !BP, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 5, 1, 16'h0000, 16'h1234, 0, 0));
    // Two in flight to r2, then simultaneous issue+retire, then two retires.
    add(mk(0, 1, 2, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 1, 2, 0, 0, 16'h0000,  2, 1, 0, 0, 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 1, 2, 1, 2, 16'h5555,  2, 1, 0, 0, BP ? 16'h5555 : 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  2, 1, 0, 0, 16'h5555, 16'h0000, 1, 0));
    add(mk(0, 0, 0, 1, 2, 16'h6666,  2, 1, 0, 0, BP ? 16'h6666 : 16'h5555, 16'h0000, 1, 0));
    add(mk(0, 0, 0, 1, 2, 16'h7777,  2, 1, 0, 0, BP ? 16'h7777 : 16'h6666, 16'h0000, !BP, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  2, 1, 0, 0, 16'h7777, 16'h0000, 0, 0));
    // Pending r6 selected but not used: no stall; then retire.
    add(mk(0, 1, 6, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  6, 0, 6, 0, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 1, 6, 16'h0606,  0, 0, 6, 1, 16'h0000, BP ? 16'h0606 : 16'h0000, !BP, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 6, 1, 16'h0000, 16'h0606, 0, 0));
    // Underflow: retire r1 with nothing in flight still writes the data.
    add(mk(0, 0, 0, 1, 1, 16'h1111,  1, 0, 0, 0, BP ? 16'h1111 : 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 0, 16'h1111, 16'h0000, 0, 1));
    add(mk(1, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 0, 16'h1111, 16'h0000, 0, 1));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
    // Overflow: four issues to r7 saturate at three.
    add(mk(0, 1, 7, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0000, 0, 0));
    add(mk(0, 1, 7, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 1, 7, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 1, 7, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0000, 1, 0));
    add(mk(0, 0, 0, 1, 7, 16'h0007,  0, 0, 7, 1, 16'h0000, BP ? 16'h0007 : 16'h0000, 1, 1));
    add(mk(0, 0, 0, 1, 7, 16'h0070,  0, 0, 7, 1, 16'h0000, BP ? 16'h0070 : 16'h0007, 1, 1));
    add(mk(0, 0, 0, 1, 7, 16'h0700,  0, 0, 7, 1, 16'h0000, BP ? 16'h0700 : 16'h0070, !BP, 1));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0700, 0, 1));
    add(mk(1, 0, 0, 0, 0, 16'h0000,  0, 0, 7, 0, 16'h0000, 16'h0700, 0, 1));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 0, 7, 1, 16'h0000, 16'h0000, 0, 0));
    // Reset mid-flight: rst with a retiring write to r4 discards everything.
    add(mk(0, 1, 4, 0, 0, 16'h0000,  4, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
    add(mk(1, 0, 0, 1, 4, 16'hAAAA,  4, 1, 0, 0, BP ? 16'hAAAA : 16'h0000, 16'h0000, !BP, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  4, 1, 0, 0, 16'h0000, 16'h0000, 0, 0));
    // Independent counters: issue r0 while retiring (underflowing) r3 in the same cycle.
    add(mk(0, 1, 0, 1, 3, 16'h0033,  0, 1, 3, 1, 16'h0000, BP ? 16'h0033 : 16'h0000, 0, 0));
    add(mk(0, 0, 0, 0, 0, 16'h0000,  0, 1, 3, 1, 16'h0000, 16'h0033, 1, 1));

    for (int i = 0; i < nv; i++) begin
      apply(i, vecs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regfile_scoreboard
`default_nettype wire
